// File: rtl/alu_req_dispatch_pkg.sv
// rtl/alu_req_dispatch_pkg.sv - shared helpers for the ALU request dispatcher
package alu_dispatch_pkg;

    function automatic int pkts(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    function automatic int pid_w(input int num_threads, input int num_lanes);
        return (pkts(num_threads, num_lanes) > 1) ? $clog2(pkts(num_threads, num_lanes)) : 1;
    endfunction

    // Batch-mask scans; an empty mask yields index 0.
    function automatic logic [31:0] first_set(input logic [31:0] mask);
        logic [31:0] idx;
        logic        found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (mask[i] && !found) begin
                idx   = 32'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [31:0] next_set(input logic [31:0] mask, input logic [31:0] cur);
        logic [31:0] idx;
        logic        found;
        idx   = cur;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (mask[i] && (32'(i) > cur) && !found) begin
                idx   = 32'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [31:0] last_set(input logic [31:0] mask);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (mask[i]) idx = 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - synchronous FIFO with head read port
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DATAW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATAW-1:0]         push_data,
    input  logic                     pop,
    output logic [DATAW-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/alu_req_dispatch.sv
// rtl/alu_req_dispatch.sv - queues ALU requests and slices them into per-channel thread batches
module alu_req_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int NUM_ALUS    = 2,
    parameter int DEPTH       = 4,
    parameter int XLEN        = 32,
    parameter int META_W      = 64,
    parameter int WID_W       = 2,
    localparam int PID_W      = pid_w(NUM_THREADS, NUM_LANES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic [WID_W-1:0]                  req_wid,
    input  logic [META_W-1:0]                 req_meta,
    input  logic [NUM_THREADS-1:0]            req_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]       req_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0]       req_rs2_data,
    output logic                              req_ready,
    output logic [NUM_ALUS-1:0]               out_valid,
    output logic [NUM_ALUS*META_W-1:0]        out_meta,
    output logic [NUM_ALUS*NUM_LANES-1:0]     out_tmask,
    output logic [NUM_ALUS*NUM_LANES*XLEN-1:0] out_rs1_data,
    output logic [NUM_ALUS*NUM_LANES*XLEN-1:0] out_rs2_data,
    output logic [NUM_ALUS*PID_W-1:0]         out_pid,
    output logic [NUM_ALUS-1:0]               out_sop,
    output logic [NUM_ALUS-1:0]               out_eop,
    input  logic [NUM_ALUS-1:0]               out_ready
);
    localparam int NUM_PKTS = pkts(NUM_THREADS, NUM_LANES);
    localparam int CH_W     = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;
    localparam int BATCH_W  = NUM_LANES * XLEN;

    typedef struct packed {
        logic [WID_W-1:0]            wid;
        logic [META_W-1:0]           meta;
        logic [NUM_THREADS-1:0]      tmask;
        logic [NUM_THREADS*XLEN-1:0] rs1;
        logic [NUM_THREADS*XLEN-1:0] rs2;
    } entry_t;

    typedef struct packed {
        logic [META_W-1:0]    meta;
        logic [NUM_LANES-1:0] tmask;
        logic [BATCH_W-1:0]   rs1;
        logic [BATCH_W-1:0]   rs2;
        logic [PID_W-1:0]     pid;
        logic                 sop;
        logic                 eop;
    } out_reg_t;

    entry_t              push_entry;
    entry_t              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                push;
    logic                pop;
    logic                issue;
    logic [CH_W-1:0]     ch;
    logic [31:0]         bp;
    logic [PID_W-1:0]    pid_q;
    logic                mid_q;
    logic [PID_W-1:0]    cur_pid;
    logic [PID_W-1:0]    pid_next;
    logic                is_eop;
    out_reg_t            nxt;
    out_reg_t            out_q [NUM_ALUS];
    logic [NUM_ALUS-1:0] out_valid_q;
    logic                unused_bits;

    assign push_entry  = {req_wid, req_meta, req_tmask, req_rs1_data, req_rs2_data};
    assign req_ready   = !fifo_full;
    assign push        = req_valid && req_ready;
    assign unused_bits = &{1'b0, fifo_count, head.wid};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .DATAW ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // mid_q marks a head whose first batch already went out; otherwise start at its first present batch.
    always_comb begin
        bp = '0;
        for (int i = 0; i < NUM_PKTS; i++) begin
            bp[i] = |head.tmask[i*NUM_LANES +: NUM_LANES];
        end
        ch       = (NUM_ALUS > 1) ? head.wid[CH_W-1:0] : '0;
        cur_pid  = mid_q ? pid_q : PID_W'(first_set(bp));
        pid_next = PID_W'(next_set(bp, 32'(cur_pid)));
        is_eop   = (bp == '0) || (32'(cur_pid) == last_set(bp));
        issue    = !fifo_empty && (!out_valid_q[ch] || out_ready[ch]);
        pop      = issue && is_eop;

        nxt.meta  = head.meta;
        nxt.tmask = head.tmask[cur_pid*NUM_LANES +: NUM_LANES];
        nxt.rs1   = head.rs1[cur_pid*BATCH_W +: BATCH_W];
        nxt.rs2   = head.rs2[cur_pid*BATCH_W +: BATCH_W];
        nxt.pid   = cur_pid;
        nxt.sop   = !mid_q;
        nxt.eop   = is_eop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pid_q <= '0;
            mid_q <= 1'b0;
        end else if (issue) begin
            mid_q <= !is_eop;
            pid_q <= is_eop ? '0 : pid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= '0;
        end else begin
            for (int c = 0; c < NUM_ALUS; c++) begin
                if (issue && (ch == CH_W'(c))) out_valid_q[c] <= 1'b1;
                else if (out_ready[c])          out_valid_q[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_ALUS; c++) begin
            if (issue && (ch == CH_W'(c))) out_q[c] <= nxt;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        for (int c = 0; c < NUM_ALUS; c++) begin
            out_meta[c*META_W +: META_W]         = out_q[c].meta;
            out_tmask[c*NUM_LANES +: NUM_LANES]  = out_q[c].tmask;
            out_rs1_data[c*BATCH_W +: BATCH_W]   = out_q[c].rs1;
            out_rs2_data[c*BATCH_W +: BATCH_W]   = out_q[c].rs2;
            out_pid[c*PID_W +: PID_W]            = out_q[c].pid;
            out_sop[c]                           = out_q[c].sop;
            out_eop[c]                           = out_q[c].eop;
        end
    end

endmodule

// File: tb/tb_alu_req_dispatch.sv
// tb/tb_alu_req_dispatch.sv - scoreboard bench for alu_req_dispatch
module tb_alu_req_dispatch;
    localparam int NT = 4, NL = 2, NA = 2, XL = 32, MW = 64, WW = 2, NP = NT / NL;

    typedef struct packed {
        logic [MW-1:0]    meta;
        logic [NL-1:0]    tmask;
        logic [NL*XL-1:0] rs1;
        logic [NL*XL-1:0] rs2;
        logic             pid;
        logic             sop;
        logic             eop;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req_valid = 1'b0;
    logic [WW-1:0]        req_wid = '0;
    logic [MW-1:0]        req_meta = '0;
    logic [NT-1:0]        req_tmask = '0;
    logic [NT*XL-1:0]     req_rs1_data = '0;
    logic [NT*XL-1:0]     req_rs2_data = '0;
    logic                 req_ready;
    logic [NA-1:0]        out_valid;
    logic [NA*MW-1:0]     out_meta;
    logic [NA*NL-1:0]     out_tmask;
    logic [NA*NL*XL-1:0]  out_rs1_data;
    logic [NA*NL*XL-1:0]  out_rs2_data;
    logic [NA-1:0]        out_pid;
    logic [NA-1:0]        out_sop;
    logic [NA-1:0]        out_eop;
    logic [NA-1:0]        out_ready = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   xfer_log[$];

    alu_req_dispatch #(
        .NUM_THREADS(NT), .NUM_LANES(NL), .NUM_ALUS(NA), .DEPTH(4),
        .XLEN(XL), .META_W(MW), .WID_W(WW)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid),
        .req_meta(req_meta), .req_tmask(req_tmask), .req_rs1_data(req_rs1_data),
        .req_rs2_data(req_rs2_data), .req_ready(req_ready), .out_valid(out_valid),
        .out_meta(out_meta), .out_tmask(out_tmask), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_pid(out_pid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        logic have;
        cyc++;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            for (int c = 0; c < NA; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    got = {out_meta[c*MW +: MW], out_tmask[c*NL +: NL], out_rs1_data[c*NL*XL +: NL*XL],
                           out_rs2_data[c*NL*XL +: NL*XL], out_pid[c], out_sop[c], out_eop[c]};
                    e = '0;
                    if (c == 0) begin
                        have = (q0.size() != 0);
                        if (have) e = q0.pop_front();
                    end else begin
                        have = (q1.size() != 0);
                        if (have) e = q1.pop_front();
                    end
                    checks++;
                    assert (have === 1'b1) else begin
                        errors++;
                        $error("FAIL unexpected_batch ch%0d got %h exp none", c, got);
                    end
                    if (have) begin
                        checks++;
                        assert (got === e) else begin
                            errors++;
                            $error("FAIL batch_ch%0d got %h exp %h", c, got, e);
                        end
                    end
                    xfer_log.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference slicing of one packet into expected batches for its channel.
    task automatic expect_pkt(input logic [WW-1:0] wid, input logic [MW-1:0] meta,
                              input logic [NT-1:0] tm, input logic [NT*XL-1:0] r1,
                              input logic [NT*XL-1:0] r2);
        logic [NP-1:0] bp;
        int            last;
        logic          first;
        exp_t          e;
        last = 0;
        for (int i = 0; i < NP; i++) begin
            bp[i] = |tm[i*NL +: NL];
            if (bp[i]) last = i;
        end
        first = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (bp[i] || (bp == '0 && i == 0)) begin
                e.meta  = meta;
                e.tmask = tm[i*NL +: NL];
                e.rs1   = r1[i*NL*XL +: NL*XL];
                e.rs2   = r2[i*NL*XL +: NL*XL];
                e.pid   = i[0];
                e.sop   = first;
                e.eop   = (bp == '0) || (i == last);
                first   = 1'b0;
                if (wid[0]) q1.push_back(e);
                else        q0.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [WW-1:0] wid, input logic [MW-1:0] meta,
                         input logic [NT-1:0] tm, input logic [NT*XL-1:0] r1,
                         input logic [NT*XL-1:0] r2);
        req_wid = wid; req_meta = meta; req_tmask = tm;
        req_rs1_data = r1; req_rs2_data = r2; req_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the handshake edge.
    task automatic send(input logic [WW-1:0] wid, input logic [MW-1:0] meta,
                        input logic [NT-1:0] tm, input logic [NT*XL-1:0] r1,
                        input logic [NT*XL-1:0] r2);
        int n;
        drive(wid, meta, tm, r1, r2);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (req_ready === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout got %b exp 1", req_ready);
        end
        if (req_ready) expect_pkt(wid, meta, tm, r1, r2);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || out_valid != '0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL drain_timeout got %0d exp <200", n);
        end
        step();
    endtask

    function automatic logic [NT*XL-1:0] rnd_ops();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int   acc;
        int   base;
        int   n;
        logic r;

        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        assert (out_valid === 2'b00) else begin errors++; $error("FAIL rst_valid got %b exp 00", out_valid); end
        checks++;
        assert (req_ready === 1'b1) else begin errors++; $error("FAIL rst_ready got %b exp 1", req_ready); end

        // Full-mask packet on ch1; check first-batch latency and layout directly.
        out_ready = 2'b11;
        send(2'd1, 64'hA1, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
        step();
        checks++;
        assert (out_valid === 2'b10) else begin errors++; $error("FAIL lat_valid got %b exp 10", out_valid); end
        checks++;
        assert (out_rs1_data[127:64] === {32'd2, 32'd1}) else begin
            errors++; $error("FAIL b0_rs1 got %h exp %h", out_rs1_data[127:64], {32'd2, 32'd1});
        end
        checks++;
        assert ({out_sop[1], out_eop[1], out_pid[1]} === 3'b100) else begin
            errors++; $error("FAIL b0_flags got %b exp 100", {out_sop[1], out_eop[1], out_pid[1]});
        end
        wait_drain();

        // Sparse and empty masks.
        send(2'd0, 64'hB2, 4'b1100, rnd_ops(), rnd_ops());
        send(2'd3, 64'hB3, 4'b0000, rnd_ops(), rnd_ops());
        send(2'd2, 64'hB4, 4'b0110, rnd_ops(), rnd_ops());
        wait_drain();

        // Back-pressure on ch0 until the queue fills.
        out_ready = 2'b10;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(2'd0, 64'hC0 + 64'(i), 4'b0011, rnd_ops(), rnd_ops());
            @(negedge clk);
            r = req_ready;
            if (r) expect_pkt(2'd0, 64'hC0 + 64'(i), 4'b0011, req_rs1_data, req_rs2_data);
            step();
            if (r) acc++;
        end
        req_valid = 1'b0;
        checks++;
        assert (acc === 5) else begin errors++; $error("FAIL accepted got %0d exp 5", acc); end
        checks++;
        assert (req_ready === 1'b0) else begin errors++; $error("FAIL full_ready got %b exp 0", req_ready); end
        checks++;
        assert (out_valid === 2'b01) else begin errors++; $error("FAIL held_valid got %b exp 01", out_valid); end
        out_ready = 2'b11;
        wait_drain();

        // Head-of-line blocking: wid1 waits behind blocked wid0 packets.
        out_ready = 2'b10;
        send(2'd0, 64'hD0, 4'b0011, rnd_ops(), rnd_ops());
        send(2'd0, 64'hD1, 4'b1111, rnd_ops(), rnd_ops());
        send(2'd1, 64'hD2, 4'b1111, rnd_ops(), rnd_ops());
        repeat (4) step();
        checks++;
        assert (out_valid === 2'b01) else begin errors++; $error("FAIL hol_valid got %b exp 01", out_valid); end
        out_ready = 2'b11;
        n = 0;
        while (!out_valid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (q0.size() === 0) else begin errors++; $error("FAIL hol_order got %0d exp 0", q0.size()); end
        wait_drain();

        // Back-to-back full packets: six batches on consecutive cycles.
        base = xfer_log.size();
        send(2'd0, 64'hE0, 4'b1111, rnd_ops(), rnd_ops());
        send(2'd1, 64'hE1, 4'b1111, rnd_ops(), rnd_ops());
        send(2'd2, 64'hE2, 4'b1111, rnd_ops(), rnd_ops());
        wait_drain();
        checks++;
        assert (xfer_log.size() - base === 6) else begin
            errors++; $error("FAIL b2b_count got %0d exp 6", xfer_log.size() - base);
        end
        if (xfer_log.size() - base >= 6) begin
            checks++;
            assert (xfer_log[base+5] - xfer_log[base] === 5) else begin
                errors++; $error("FAIL b2b_span got %0d exp 5", xfer_log[base+5] - xfer_log[base]);
            end
        end

        // Reset while a packet is half issued.
        out_ready = 2'b00;
        send(2'd1, 64'hF0, 4'b1111, rnd_ops(), rnd_ops());
        step();
        checks++;
        assert (out_valid === 2'b10) else begin errors++; $error("FAIL half_valid got %b exp 10", out_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++;
        assert (out_valid === 2'b00) else begin errors++; $error("FAIL mid_rst_valid got %b exp 00", out_valid); end
        checks++;
        assert (req_ready === 1'b1) else begin errors++; $error("FAIL mid_rst_ready got %b exp 1", req_ready); end
        out_ready = 2'b11;
        send(2'd1, 64'hF1, 4'b1111, rnd_ops(), rnd_ops());
        step();
        checks++;
        assert ({out_valid[1], out_sop[1], out_pid[1]} === 3'b110) else begin
            errors++; $error("FAIL post_rst_first got %b exp 110", {out_valid[1], out_sop[1], out_pid[1]});
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
